// File: rtl/fetch_decode_buffer_if.sv
// Fetch/decode-side signal bundle for the fetch-decode buffer.
// slave = the buffer itself, master = the fetch/decode environment driving it.
interface fetch_decode_buffer_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = 32
);
  logic [ADDR_W-1:0]        if_pc;
  logic [INSTR_W-1:0]       if_instr;
  logic                     if_valid;
  logic                     pc_write;
  logic [ADDR_W-1:0]        id_pc;
  logic [INSTR_W-1:0]       id_instr;
  logic                     id_valid;
  logic                     id_ready;
  logic                     flush;
  logic [$clog2(DEPTH):0]   count;
  logic [CNT_W-1:0]         stall_cycles;

  modport slave (
    input  if_pc, if_instr, if_valid, id_ready, flush,
    output pc_write, id_pc, id_instr, id_valid, count, stall_cycles
  );

  modport master (
    output if_pc, if_instr, if_valid, id_ready, flush,
    input  pc_write, id_pc, id_instr, id_valid, count, stall_cycles
  );
endinterface

// File: rtl/fetch_decode_buffer.sv
// In-order {PC, instruction} FIFO between fetch and decode; freezes the PC
// when full, drops everything on flush, and counts fetch-stall cycles.
module fetch_decode_buffer #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_decode_buffer_if.slave  bus
);
  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_BITS = $clog2(DEPTH) + 1;
  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(32'h0000_0013);

  logic [ADDR_W-1:0]   r_pc    [DEPTH];
  logic [INSTR_W-1:0]  r_instr [DEPTH];
  logic [PTR_W-1:0]    r_wr;
  logic [PTR_W-1:0]    r_rd;
  logic [CNT_BITS-1:0] r_count;
  logic [CNT_W-1:0]    r_stall;

  logic w_full;
  logic w_empty;
  logic w_enq;
  logic w_deq;
  logic w_stall;

  assign w_full  = (r_count == CNT_BITS'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_enq   = bus.if_valid && !w_full && !bus.flush;
  assign w_deq   = !w_empty && bus.id_ready && !bus.flush;
  // A fetch being redirected by a flush is discarded, not stalled.
  assign w_stall = bus.if_valid && w_full && !bus.flush && (r_stall != '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_stall <= '0;
    end else begin
      if (w_stall)
        r_stall <= r_stall + CNT_W'(1);
      if (bus.flush) begin
        r_wr    <= '0;
        r_rd    <= '0;
        r_count <= '0;
      end else begin
        if (w_enq) begin
          r_pc[r_wr]    <= bus.if_pc;
          r_instr[r_wr] <= bus.if_instr;
          r_wr          <= r_wr + PTR_W'(1);
        end
        if (w_deq)
          r_rd <= r_rd + PTR_W'(1);
        case ({w_enq, w_deq})
          2'b10:   r_count <= r_count + CNT_BITS'(1);
          2'b01:   r_count <= r_count - CNT_BITS'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Head is a plain combinational read; no same-cycle fetch bypass.
  assign bus.pc_write     = !w_full;
  assign bus.id_valid     = !w_empty;
  assign bus.id_pc        = w_empty ? '0  : r_pc[r_rd];
  assign bus.id_instr     = w_empty ? NOP : r_instr[r_rd];
  assign bus.count        = r_count;
  assign bus.stall_cycles = r_stall;
endmodule
